// File: rtl/dmem_arbiter_if.sv
//----------------------------------------------------------------------------
// Module      : dmem_arbiter_if
// Description : Bundle of the CPU (MEM stage) port, the host/debug loader
//               port and the single-port data memory port shared by
//               dmem_arbiter.
//               master : requesters and memory side (pipeline, host, RAM)
//               slave  : the arbiter itself
// Ports       : cpu_*  - MEM stage load/store request, data and stall
//               host_* - host request/ack handshake with registered results
//               mem_*  - data memory address, write data, write enable and
//                        combinational read data
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if;

  // CPU (MEM stage) port
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  // Host / debug loader port
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic        host_err;
  logic [31:0] host_rdata;

  // Data memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic        mem_we;
  logic [31:0] mem_dataout;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_err, host_rdata,
    input  mem_addr, mem_datain, mem_we,
    output mem_dataout
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_err, host_rdata,
    output mem_addr, mem_datain, mem_we,
    input  mem_dataout
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//----------------------------------------------------------------------------
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the pipeline MEM
//               stage (CPU) and a host/debug loader. The CPU has priority;
//               the host is served in idle MEM cycles, or force-granted
//               after MAX_WAIT consecutive blocked cycles, which stalls the
//               CPU for one cycle. Each host word takes a grant cycle and
//               an ack cycle.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - dmem_arbiter_if.slave (CPU, host and memory ports)
// Parameters  : MAX_WAIT - blocked cycles before a forced host grant
//                          (0 = host wins whenever it requests)
//               WAIT_W   - starvation counter width, must hold MAX_WAIT
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_wait_one = WAIT_W'(1);

  typedef enum logic [0:0] {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } hstate_t;

  hstate_t           r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_host_ack;
  logic              r_host_err;
  logic [31:0]       r_host_rdata;

  logic              w_host_misaligned;
  logic              w_host_grant;
  logic [31:0]       w_mem_addr;
  logic [31:0]       w_mem_datain;
  logic              w_mem_we;

  assign w_host_misaligned = (bus.host_addr[1:0] != 2'b00);

  // The host only wins from H_IDLE: when the CPU is idle, or once it has
  // been held off for MAX_WAIT consecutive cycles.
  assign w_host_grant = (r_state == H_IDLE) && bus.host_req &&
                        (!bus.cpu_req || (r_wait_cnt == c_max_wait));

  //--------------------------------------------------------------------------
  // Memory port mux
  //--------------------------------------------------------------------------
  always_comb begin
    w_mem_addr   = bus.cpu_addr;
    w_mem_datain = bus.cpu_wdata;
    w_mem_we     = bus.cpu_req && bus.cpu_we;
    if (w_host_grant) begin
      w_mem_addr   = bus.host_addr;
      w_mem_datain = bus.host_wdata;
      // A misaligned host access is acked with an error and never written.
      w_mem_we     = bus.host_we && !w_host_misaligned;
    end
    // The memory writes on the clock edge; keep it quiet while the arbiter
    // is held in reset so no stray write lands during that window.
    if (rst) begin
      w_mem_we = 1'b0;
    end
  end

  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_datain = w_mem_datain;
  assign bus.mem_we     = w_mem_we;

  // The CPU sees the memory directly; a stalled CPU simply repeats its
  // request, so no CPU state is held here.
  assign bus.cpu_rdata  = bus.mem_dataout;
  assign bus.cpu_stall  = bus.cpu_req && w_host_grant;

  //--------------------------------------------------------------------------
  // Host FSM, starvation counter and registered host results
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= H_IDLE;
      r_wait_cnt   <= '0;
      r_host_ack   <= 1'b0;
      r_host_err   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= w_host_grant;

      case (r_state)
        H_IDLE: begin
          if (w_host_grant) begin
            r_state      <= H_ACK;
            r_wait_cnt   <= '0;
            r_host_err   <= w_host_misaligned;
            r_host_rdata <= (bus.host_we || w_host_misaligned) ? 32'h0
                                                               : bus.mem_dataout;
          end else if (!bus.host_req) begin
            r_wait_cnt <= '0;
          end else if (bus.cpu_req && (r_wait_cnt != c_max_wait)) begin
            r_wait_cnt <= r_wait_cnt + c_wait_one;
          end
        end

        H_ACK: begin
          // Ack cycle: any host request is ignored; the next word can be
          // granted at the earliest on the following cycle.
          r_state <= H_IDLE;
          if (!bus.host_req) begin
            r_wait_cnt <= '0;
          end
        end

        default: begin
          r_state <= H_IDLE;
        end
      endcase
    end
  end

  assign bus.host_ack   = r_host_ack;
  assign bus.host_err   = r_host_err;
  assign bus.host_rdata = r_host_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//----------------------------------------------------------------------------
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: directed scenarios
//               followed by random CPU/host traffic, compared against a
//               behavioural model of the arbitration rules and memory.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus variables
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;

  assign bus.cpu_req    = c_req;
  assign bus.cpu_we     = c_we;
  assign bus.cpu_addr   = c_addr;
  assign bus.cpu_wdata  = c_wdata;
  assign bus.host_req   = h_req;
  assign bus.host_we    = h_we;
  assign bus.host_addr  = h_addr;
  assign bus.host_wdata = h_wdata;

  // Data memory: combinational read, write on rising edge, backdoor preload
  logic [31:0] mem [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  assign bus.mem_dataout = mem[bus.mem_addr[6:2]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_datain;
  end

  // Behavioural model state
  logic [31:0] ref_mem [32];
  bit          m_ack;      // host is being acknowledged this cycle
  int          m_blk;      // consecutive cycles the host has been held off
  logic        m_err;
  logic [31:0] m_rdata;

  // Sampled observations
  logic        s_stall, s_we, s_ack, s_err;
  logic [31:0] s_addr, s_rdata, s_crdata;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ack = 0; m_blk = 0; m_err = 1'b0; m_rdata = '0;
  endtask

  // One clock cycle with inputs already applied (inputs change at posedge+1).
  task automatic tick();
    bit          g, mis, owe, n_err;
    logic [31:0] oaddr, odata, n_rdata;
    #1;
    mis   = (h_addr[1:0] != 2'b00);
    g     = !m_ack && h_req && (!c_req || m_blk == MAX_WAIT);
    oaddr = g ? h_addr : c_addr;
    odata = g ? h_wdata : c_wdata;
    owe   = g ? (h_we && !mis) : (c_req && c_we);
    s_stall  = bus.cpu_stall;
    s_we     = bus.mem_we;
    s_addr   = bus.mem_addr;
    s_crdata = bus.cpu_rdata;
    chk("cpu_stall",  s_stall, 32'(c_req && g));
    chk("mem_we",     s_we, 32'(owe));
    chk("mem_addr",   s_addr, oaddr);
    chk("mem_datain", bus.mem_datain, odata);
    chk("cpu_rdata",  s_crdata, ref_mem[oaddr[6:2]]);
    n_err   = g ? mis : m_err;
    n_rdata = g ? ((h_we || mis) ? 32'h0 : ref_mem[h_addr[6:2]]) : m_rdata;
    @(posedge clk);
    if (owe) ref_mem[oaddr[6:2]] = odata;
    if (g || !h_req) m_blk = 0;
    else if (!m_ack && c_req && m_blk < MAX_WAIT) m_blk++;
    m_ack = g; m_err = n_err; m_rdata = n_rdata;
    #1;
    s_ack = bus.host_ack; s_err = bus.host_err; s_rdata = bus.host_rdata;
    chk("host_ack", s_ack, 32'(m_ack));
    if (m_ack) begin
      chk("host_err",   s_err, 32'(m_err));
      chk("host_rdata", s_rdata, m_rdata);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    c_req = req; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    h_req = req; h_we = we; h_addr = a; h_wdata = d;
  endtask

  initial begin
    model_reset();
    set_cpu(1, 1, 32'h40, 32'h1111_2222);
    #1;
    // Preload memory while the arbiter is held in reset
    for (int i = 0; i < 32; i++) begin
      bd_we = 1'b1; bd_addr = 5'(i);
      bd_data = (i == 20) ? 32'h0000_00a3 : $urandom;
      ref_mem[i] = bd_data;
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
    // Reset state
    chk("rst_host_ack",   bus.host_ack, 32'h0);
    chk("rst_host_err",   bus.host_err, 32'h0);
    chk("rst_host_rdata", bus.host_rdata, 32'h0);
    chk("rst_mem_we",     bus.mem_we, 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    rst = 1'b0;

    // 1: host read with idle CPU
    set_host(1, 0, 32'h50, 32'h0);
    tick();
    chk("t1_stall", s_stall, 32'h0);
    chk("t1_ack",   s_ack, 32'h1);
    chk("t1_rdata", s_rdata, 32'h0000_00a3);
    chk("t1_err",   s_err, 32'h0);
    set_host(0, 0, 32'h0, 32'h0);
    tick();

    // 2: CPU loads every cycle; host write is forced in after MAX_WAIT
    set_cpu(1, 0, 32'h54, 32'h0);
    set_host(1, 1, 32'h60, 32'hDEAD_BEEF);
    for (int i = 0; i <= MAX_WAIT; i++) begin
      tick();
      chk("t2_stall", s_stall, 32'(i == MAX_WAIT));
      chk("t2_ack",   s_ack, 32'(i == MAX_WAIT));
      if (i == MAX_WAIT) begin
        chk("t2_we",   s_we, 32'h1);
        chk("t2_addr", s_addr, 32'h60);
      end
    end
    set_host(0, 0, 32'h0, 32'h0);
    set_cpu(1, 0, 32'h60, 32'h0);
    tick();
    chk("t2_readback", s_crdata, 32'hDEAD_BEEF);

    // 3: host request held across acks, CPU idle
    set_cpu(0, 0, 32'h0, 32'h0);
    set_host(1, 1, 32'h64, 32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_we",  s_we, 32'((i % 2) == 0));
      chk("t3_ack", s_ack, 32'((i % 2) == 0));
    end
    set_host(0, 0, 32'h0, 32'h0);
    tick();

    // 4: misaligned host write
    set_host(1, 1, 32'h62, 32'hFFFF_0000);
    tick();
    chk("t4_we",    s_we, 32'h0);
    chk("t4_ack",   s_ack, 32'h1);
    chk("t4_err",   s_err, 32'h1);
    chk("t4_rdata", s_rdata, 32'h0);
    set_host(0, 0, 32'h0, 32'h0);
    set_cpu(1, 0, 32'h60, 32'h0);
    tick();
    chk("t4_unchanged", s_crdata, 32'hDEAD_BEEF);

    // 5: forced host write collides with CPU store to the same word
    set_host(1, 1, 32'h58, 32'h1);
    set_cpu(1, 1, 32'h5c, 32'h5c5c_5c5c);
    for (int i = 0; i < MAX_WAIT; i++) tick();
    set_cpu(1, 1, 32'h58, 32'h79);
    tick();
    chk("t5_stall", s_stall, 32'h1);
    set_host(0, 0, 32'h0, 32'h0);
    tick();
    chk("t5_retry_stall", s_stall, 32'h0);
    set_cpu(1, 0, 32'h58, 32'h0);
    tick();
    chk("t5_final", s_crdata, 32'h79);

    // 6: reset during the ack cycle
    set_cpu(0, 0, 32'h0, 32'h0);
    set_host(1, 0, 32'h44, 32'h0);
    tick();
    chk("t6_ack_before", s_ack, 32'h1);
    set_host(0, 0, 32'h0, 32'h0);
    set_cpu(1, 1, 32'h48, 32'hCAFE_0048);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_ack_drop", bus.host_ack, 32'h0);
    chk("t6_rdata",    bus.host_rdata, 32'h0);
    chk("t6_we",       bus.mem_we, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("t6_stall", s_stall, 32'h0);
    chk("t6_cpu_we", s_we, 32'h1);

    // Random traffic against the model
    set_cpu(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (!h_req || m_ack) begin
        h_req   = ($urandom_range(0, 9) < 6);
        h_we    = 1'($urandom);
        h_addr  = $urandom;
        if ($urandom_range(0, 3) != 0) h_addr[1:0] = 2'b00;
        h_wdata = $urandom;
      end
      if (!s_stall) begin
        c_req   = ($urandom_range(0, 9) < 7);
        c_we    = 1'($urandom);
        c_addr  = $urandom & 32'hFFFF_FFFC;
        c_wdata = $urandom;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
